// File: rtl/fp_pkg.sv
// Shared binary32 format constants, unpacked-operand type and the unpack helper
// used by the floating-point adder.
package fp_pkg;

    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int SIG_W   = FRAC_W + 1;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig;
        logic             is_zero;
        logic             is_inf;
        logic             is_nan;
    } fp_unpacked_t;

    // Subnormals are flushed: any exp==0 encoding counts as a zero of its sign.
    function automatic fp_unpacked_t fp_unpack(input logic [31:0] w);
        fp_unpacked_t u;
        u.sign    = w[31];
        u.exp     = w[30:23];
        u.sig     = {1'b1, w[22:0]};
        u.is_zero = (w[30:23] == '0);
        u.is_inf  = (w[30:23] == EXP_W'(EXP_MAX)) && (w[22:0] == '0);
        u.is_nan  = (w[30:23] == EXP_W'(EXP_MAX)) && (w[22:0] != '0);
        return u;
    endfunction

endpackage

// File: rtl/fp_lzc24.sv
// Leading-zero counter for the 24-bit significand; flags an all-zero input.
module fp_lzc24 (
    input  logic [23:0] data_i,
    output logic [4:0]  count_o,
    output logic        zero_o
);

    always_comb begin
        // NOTE: assign a default before any conditional write so no latch is inferred.
        count_o = 5'd0;
        // Ascending scan: the highest set bit is written last and wins.
        for (int i = 0; i < 24; i++) begin
            if (data_i[i]) begin
                count_o = 5'(23 - i);
            end
        end
    end

    assign zero_o = (data_i == '0);

endmodule

// File: rtl/fp_add.sv
// Single-cycle binary32 adder: combinational align/add/normalize/round with
// one output register; round-to-nearest-even, subnormals flushed to zero.
module fp_add
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       A_FP,
    input  logic [31:0]       B_FP,
    output logic              sign,
    output logic [EXP_W-1:0]  exponent,
    output logic [FRAC_W-1:0] mantissa
);

    fp_unpacked_t     a_u, b_u;
    logic             big_sign, small_sign;
    logic [EXP_W-1:0] big_exp, small_exp, exp_diff;
    logic [SIG_W-1:0] big_sig, small_sig;
    logic [49:0]      wide_shift;
    logic [26:0]      small_al;
    logic [27:0]      sum_raw;

    logic [4:0]        lz_cnt, shamt;
    logic              lz_zero;
    logic [26:0]       norm;
    logic signed [9:0] exp_n, exp_f;
    logic [24:0]       mant_r;
    logic              rnd_up;
    logic [31:0]       res_d, res_q;

    always_comb begin
        a_u = fp_unpack(A_FP);
        b_u = fp_unpack(B_FP);

        // Magnitude order is plain unsigned order of {exp, frac}.
        if (A_FP[30:0] >= B_FP[30:0]) begin
            big_sign = a_u.sign;  big_exp = a_u.exp;  big_sig = a_u.sig;
            small_sign = b_u.sign; small_exp = b_u.exp; small_sig = b_u.sig;
        end else begin
            big_sign = b_u.sign;  big_exp = b_u.exp;  big_sig = b_u.sig;
            small_sign = a_u.sign; small_exp = a_u.exp; small_sig = a_u.sig;
        end

        exp_diff   = big_exp - small_exp;
        wide_shift = {small_sig, 26'b0} >> exp_diff;
        if (exp_diff >= 8'd26) begin
            small_al = 27'd1;
        end else begin
            small_al = {wide_shift[49:24], |wide_shift[23:0]};
        end

        if (big_sign ^ small_sign) begin
            sum_raw = {1'b0, big_sig, 3'b0} - {1'b0, small_al};
        end else begin
            sum_raw = {1'b0, big_sig, 3'b0} + {1'b0, small_al};
        end
    end

    fp_lzc24 u_lzc (
        .data_i  (sum_raw[26:3]),
        .count_o (lz_cnt),
        .zero_o  (lz_zero)
    );

    always_comb begin
        shamt = 5'd0;
        if (sum_raw[27]) begin
            norm  = {sum_raw[27:2], sum_raw[1] | sum_raw[0]};
            exp_n = 10'(big_exp) + 10'd1;
        end else begin
            // Upper 24 bits can only be empty after a one-place alignment, leaving the guard bit.
            shamt = lz_zero ? 5'd24 : lz_cnt;
            norm  = sum_raw[26:0] << shamt;
            exp_n = 10'(big_exp) - 10'(shamt);
        end

        rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant_r = {1'b0, norm[26:3]} + 25'(rnd_up);
        exp_f  = exp_n + 10'(mant_r[24]);

        if (a_u.is_nan || b_u.is_nan || (a_u.is_inf && b_u.is_inf && (a_u.sign != b_u.sign))) begin
            res_d = QNAN;
        end else if (a_u.is_inf) begin
            res_d = {a_u.sign, 8'hFF, 23'b0};
        end else if (b_u.is_inf) begin
            res_d = {b_u.sign, 8'hFF, 23'b0};
        end else if (a_u.is_zero && b_u.is_zero) begin
            res_d = {a_u.sign & b_u.sign, 31'b0};
        end else if (a_u.is_zero) begin
            res_d = B_FP;
        end else if (b_u.is_zero) begin
            res_d = A_FP;
        end else if (sum_raw == '0) begin
            res_d = 32'b0;
        end else if (exp_f < 10'sd1) begin
            res_d = {big_sign, 31'b0};
        end else if (exp_f >= 10'sd255) begin
            res_d = {big_sign, 8'hFF, 23'b0};
        end else begin
            res_d = {big_sign, exp_f[7:0], mant_r[22:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is written with non-blocking assignments only.
        if (rst) begin
            res_q <= 32'b0;
        end else begin
            res_q <= res_d;
        end
    end

    assign sign     = res_q[31];
    assign exponent = res_q[30:23];
    assign mantissa = res_q[22:0];

endmodule

// File: tb/tb_fp_add.sv
// Self-checking bench for fp_add: real-arithmetic reference model, per-cycle
// stream compare, and directed vectors with hand-computed results.
module tb_fp_add;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a_fp, b_fp;
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
    logic [31:0] dut_word;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_word;
    bit          exp_valid = 1'b0;

    always #5 clk = ~clk;

    fp_add dut (
        .clk      (clk),
        .rst      (rst),
        .A_FP     (a_fp),
        .B_FP     (b_fp),
        .sign     (sign),
        .exponent (exponent),
        .mantissa (mantissa)
    );

    assign dut_word = {sign, exponent, mantissa};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h (A=%08h B=%08h)", name, act, expv, a_fp, b_fp);
        end
    endtask

    function automatic real pow2(input int e);
        real r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else        for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real to_real(input logic [31:0] w);
        real v;
        if (w[30:23] == 8'h00) return 0.0;
        v = (1.0 + real'(w[22:0]) / 8388608.0) * pow2(int'(w[30:23]) - 127);
        return w[31] ? -v : v;
    endfunction

    // Exact sum in double precision, then rounded to binary32 with RNE,
    // flush-to-zero underflow and overflow to infinity.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
        logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, s;
        real  sum, mag, m, rem;
        int   e, fl, be;
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        a_zero = (a[30:23] == 8'h00);
        b_zero = (b[30:23] == 8'h00);
        if (a_nan || b_nan || (a_inf && b_inf && a[31] != b[31])) return 32'h7FC00000;
        if (a_inf) return a;
        if (b_inf) return b;
        if (a_zero && b_zero) return {a[31] & b[31], 31'b0};
        sum = to_real(a) + to_real(b);
        if (sum == 0.0) return 32'h0;
        s   = (sum < 0.0);
        mag = s ? -sum : sum;
        e   = 0;
        while (mag >= 2.0) begin mag = mag / 2.0; e++; end
        while (mag < 1.0)  begin mag = mag * 2.0; e--; end
        m   = mag * 8388608.0;
        fl  = $rtoi(m);
        rem = m - real'(fl);
        if (rem > 0.5 || (rem == 0.5 && fl[0])) fl++;
        if (fl == (1 << 24)) begin fl = 1 << 23; e++; end
        be = e + 127;
        if (be < 1)   return {s, 31'b0};
        if (be >= 255) return {s, 8'hFF, 23'b0};
        return {s, be[7:0], fl[22:0]};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_valid = 1'b0;
        end else begin
            exp_word  = model(a_fp, b_fp);
            exp_valid = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst && exp_valid) check("stream", dut_word, exp_word);
    end

    task automatic apply(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expv);
        @(negedge clk);
        a_fp = a;
        b_fp = b;
        @(posedge clk);
        #1;
        check({name, " dut"}, dut_word, expv);
        check({name, " model"}, model(a, b), expv);
    endtask

    function automatic logic [7:0] pick_exp();
        case ($urandom_range(0, 3))
            0:       return 8'(1 + $urandom_range(0, 4));
            1:       return 8'(250 + $urandom_range(0, 4));
            default: return 8'(100 + $urandom_range(0, 40));
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] ea, eb;
        rst  = 1'b1;
        a_fp = 32'h0;
        b_fp = 32'h0;
        #12;
        check("reset", dut_word, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        apply("7.25+0.375",   32'h40E80000, 32'h3EC00000, 32'h40F40000);
        apply("6+7",          32'h40C00000, 32'h40E00000, 32'h41500000);
        apply("7+6 swap",     32'h40E00000, 32'h40C00000, 32'h41500000);
        apply("-7+-3",        32'hC0E00000, 32'hC0400000, 32'hC1200000);
        apply("7+-3",         32'h40E00000, 32'hC0400000, 32'h40800000);
        apply("-7+3",         32'hC0E00000, 32'h40400000, 32'hC0800000);
        apply("-3+7 swap",    32'hC0400000, 32'h40E00000, 32'h40800000);
        apply("65+-63",       32'h42820000, 32'hC27C0000, 32'h40000000);
        apply("1+-1",         32'h3F800000, 32'hBF800000, 32'h00000000);
        apply("-1+1",         32'hBF800000, 32'h3F800000, 32'h00000000);
        apply("tie even",     32'h3F800000, 32'h33800000, 32'h3F800000);
        apply("tie odd",      32'h3F800001, 32'h33800000, 32'h3F800002);
        apply("above half",   32'h3F800000, 32'h33C00000, 32'h3F800001);
        apply("overflow",     32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
        apply("inf-inf",      32'h7F800000, 32'hFF800000, 32'h7FC00000);
        apply("nan",          32'h7F800001, 32'h3F800000, 32'h7FC00000);
        apply("inf+1",        32'h3F800000, 32'h7F800000, 32'h7F800000);
        apply("-inf+-inf",    32'hFF800000, 32'hFF800000, 32'hFF800000);
        apply("-0+-0",        32'h80000000, 32'h80000000, 32'h80000000);
        apply("+0+-0",        32'h00000000, 32'h80000000, 32'h00000000);
        apply("subn+1",       32'h00000001, 32'h3F800000, 32'h3F800000);
        apply("-subn+-0",     32'h80400000, 32'h80000000, 32'h80000000);
        apply("0+x exact",    32'h00000000, 32'hC1234567, 32'hC1234567);
        apply("underflow",    32'h80800001, 32'h00800000, 32'h80000000);
        apply("1.5+1.5",      32'h3FC00000, 32'h3FC00000, 32'h40400000);

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            ea   = pick_exp();
            eb   = ($urandom_range(0, 3) == 0) ? pick_exp() : 8'(int'(ea) + $urandom_range(0, 4) - 2);
            a_fp = {1'($urandom), ea, 23'($urandom)};
            b_fp = {1'($urandom), eb, 23'($urandom)};
            if (i % 8 == 0) b_fp = {~a_fp[31], a_fp[30:0]};
        end

        @(negedge clk);
        a_fp = 32'h40E80000;
        b_fp = 32'h3EC00000;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async reset", dut_word, 32'h0);
        @(posedge clk);
        #1;
        check("held in reset", dut_word, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("after reset", dut_word, 32'h40F40000);

        @(negedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fp_add.md
FP_ADD -- requirements
Module: fp_add

Interface
REQ-001 Parameters SHALL be none; the format is fixed IEEE-754 binary32 (1 sign, 8 exponent bits with bias 127, 23 fraction bits).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 A_FP  input  32  operand A, binary32 {sign[31], exp[30:23], frac[22:0]}.
REQ-005 B_FP  input  32  operand B, same encoding.
REQ-006 sign  output  1  sign of A+B, registered.
REQ-007 exponent  output  8  biased exponent of A+B, registered.
REQ-008 mantissa  output  23  fraction field of A+B (hidden bit excluded), registered.

Function
REQ-009 Operands SHALL be sampled on every rising clk edge (no handshake); {sign,exponent,mantissa} SHALL equal the rounded sum of the operands sampled at that edge (latency 1 cycle, throughput 1 per cycle).
REQ-010 The datapath SHALL be: unpack with hidden bit 1 -> swap so the larger magnitude (exp, then frac) is the big operand -> right-shift the smaller by the exponent difference, with guard, round and sticky bits (shift >= 26 leaves only sticky) -> add when signs are equal, else subtract small from big -> normalize -> round -> pack.
REQ-011 Normalization: on carry-out, shift right 1 and exponent +1 (old LSB folds into sticky); on cancellation, shift left by the leading-zero count of the 24-bit significand and decrement the exponent by that count.
REQ-012 Rounding SHALL be round-to-nearest-even using guard/round/sticky; a rounding carry SHALL renormalize (exponent +1, fraction 0).
REQ-013 Result sign SHALL be the sign of the larger-magnitude operand; exact cancellation (x + -x) SHALL yield +0.
REQ-014 Subnormal inputs (exp=0, frac!=0) SHALL be treated as zero of the same sign (flush-to-zero).
REQ-015 A result exponent below 1 after normalization/rounding SHALL give signed zero with the computed sign.
REQ-016 A result exponent >= 255 SHALL give signed infinity (exp=0xFF, frac=0).
REQ-017 Zero + zero: -0 + -0 = -0; every other zero combination = +0. Zero + x = x exactly.
REQ-018 Any NaN operand, or +inf + -inf, SHALL yield canonical quiet NaN: sign 0, exp 0xFF, frac 0x400000.
REQ-019 inf + finite, or inf + inf of the same sign, SHALL yield that infinity.
REQ-020 The computation SHALL be symmetric: swapping A_FP and B_FP SHALL produce identical outputs.

Reset
REQ-021 While rst=1 the outputs SHALL be 0 (sign=0, exponent=0, mantissa=0) immediately, regardless of clk.
REQ-022 After rst deasserts, the first rising edge SHALL load a valid result; no other state exists.

Structure
REQ-023 A shared package fp_pkg SHALL hold EXP_W=8, FRAC_W=23, BIAS=127, EXP_MAX=255, the canonical QNAN constant and an unpacked-float struct/typedef.
REQ-024 The leading-zero count SHALL be a separate sub-module fp_lzc24 (24-bit input, 5-bit count, all-zero input flagged); all other logic stays in fp_add as combinational logic plus the single output register.

Verification
REQ-025 A=0x40E80000 (7.25), B=0x3EC00000 (0.375) -> next edge: sign=0, exponent=0x81, mantissa=0x740000 (7.625).
REQ-026 A=0x40C00000 (6), B=0x40E00000 (7) -> sign=0, exponent=0x82, mantissa=0x500000 (13); A=0xC0E00000 (-7), B=0xC0400000 (-3) -> sign=1, exponent=0x82, mantissa=0x200000 (-10).
REQ-027 A=0x40E00000 (7), B=0xC0400000 (-3) -> sign=0, exponent=0x81, mantissa=0 (4); A=0xC0E00000, B=0x40400000 -> sign=1, exponent=0x81, mantissa=0 (-4).
REQ-028 A=0x42820000 (65), B=0xC27C0000 (-63) -> sign=0, exponent=0x80, mantissa=0 (2, multi-bit cancellation); A=0x3F800000, B=0xBF800000 -> +0.
REQ-029 A=0x3F800000 (1.0), B=0x33800000 (2^-24, halfway case) -> 0x3F800000 (ties to even); A=0x7F7FFFFF, B=0x7F7FFFFF -> +inf (0x7F800000); A=0x7F800000, B=0xFF800000 -> 0x7FC00000.
REQ-030 Assert rst mid-stream with nonzero inputs applied -> outputs 0 asynchronously; release rst -> the next edge shows the correct sum of the current inputs.
